// File: rtl/accumulator_command_sequencer.sv
// Turns a valid/ready increment/load command stream into single-cycle accumulator
// pulses, waits for the accumulator update and presents it as a valid/ready result.
module accumulator_command_sequencer #(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_load,
  input  logic [WORD_WIDTH-1:0] cmd_value,
  output logic [WORD_WIDTH-1:0] acc_increment,
  output logic                  acc_increment_valid,
  output logic [WORD_WIDTH-1:0] acc_load_value,
  output logic                  acc_load_valid,
  output logic                  acc_carry_in,
  input  logic [WORD_WIDTH-1:0] acc_value,
  input  logic                  acc_updated,
  input  logic                  acc_overflow,
  input  logic                  acc_carry_out,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [WORD_WIDTH-1:0] result_value,
  output logic                  result_overflow,
  output logic                  result_carry,
  output logic                  error_spurious_update,
  output logic                  error_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [WORD_WIDTH-1:0]   held_value_q, held_value_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [WORD_WIDTH-1:0]   result_value_q, result_value_d;
  logic                    result_overflow_q, result_overflow_d;
  logic                    result_carry_q, result_carry_d;
  logic                    err_spurious_q, err_spurious_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    upd_mask_q, upd_mask_d;

  always_comb begin
    state_d           = state_q;
    is_load_d         = is_load_q;
    held_value_d      = held_value_q;
    timeout_cnt_d     = timeout_cnt_q;
    result_value_d    = result_value_q;
    result_overflow_d = result_overflow_q;
    result_carry_d    = result_carry_q;
    err_spurious_d    = err_spurious_q;
    err_timeout_d     = err_timeout_q;
    upd_mask_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          is_load_d    = cmd_is_load;
          held_value_d = cmd_value;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timeout_cnt_d = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        timeout_cnt_d = timeout_cnt_q + TIMEOUT_WIDTH'(1);
        if (acc_updated) begin
          result_value_d    = acc_value;
          result_overflow_d = acc_overflow;
          result_carry_d    = acc_carry_out;
          state_d           = RESULT;
        end else if (timeout_cnt_q == LAST_WAIT_COUNT) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      RESULT: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An update from a command dropped by clear may land in the first IDLE cycle.
    if (acc_updated && (state_q != WAIT) && !upd_mask_q) err_spurious_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q           <= IDLE;
      is_load_q         <= 1'b0;
      held_value_q      <= '0;
      timeout_cnt_q     <= '0;
      result_value_q    <= '0;
      result_overflow_q <= 1'b0;
      result_carry_q    <= 1'b0;
      err_spurious_q    <= 1'b0;
      err_timeout_q     <= 1'b0;
      upd_mask_q        <= 1'b1;
    end else begin
      state_q           <= state_d;
      is_load_q         <= is_load_d;
      held_value_q      <= held_value_d;
      timeout_cnt_q     <= timeout_cnt_d;
      result_value_q    <= result_value_d;
      result_overflow_q <= result_overflow_d;
      result_carry_q    <= result_carry_d;
      err_spurious_q    <= err_spurious_d;
      err_timeout_q     <= err_timeout_d;
      upd_mask_q        <= upd_mask_d;
    end
  end

  assign cmd_ready             = (state_q == IDLE);
  assign acc_increment         = held_value_q;
  assign acc_load_value        = held_value_q;
  assign acc_increment_valid   = (state_q == ISSUE) && !is_load_q;
  assign acc_load_valid        = (state_q == ISSUE) && is_load_q;
  assign acc_carry_in          = 1'b0;
  assign result_valid          = (state_q == RESULT);
  assign result_value          = result_value_q;
  assign result_overflow       = result_overflow_q;
  assign result_carry          = result_carry_q;
  assign error_spurious_update = err_spurious_q;
  assign error_timeout         = err_timeout_q;

endmodule

// File: tb/tb_accumulator_command_sequencer.sv
// Bench for accumulator_command_sequencer with a behavioural 8-bit accumulator
// (variable extra pipeline stages) and a result scoreboard.
module tb_accumulator_command_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic       cmd_valid, cmd_ready, cmd_is_load;
  logic [7:0] cmd_value;
  logic [7:0] acc_increment, acc_load_value, acc_value;
  logic       acc_increment_valid, acc_load_valid, acc_carry_in;
  logic       acc_updated, acc_overflow, acc_carry_out;
  logic       result_valid, result_ready, result_overflow, result_carry;
  logic [7:0] result_value;
  logic       error_spurious_update, error_timeout;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  accumulator_command_sequencer #(
    .WORD_WIDTH(8),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_WIDTH(5)
  ) dut (
    .clock(clock), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_load(cmd_is_load), .cmd_value(cmd_value),
    .acc_increment(acc_increment), .acc_increment_valid(acc_increment_valid),
    .acc_load_value(acc_load_value), .acc_load_valid(acc_load_valid),
    .acc_carry_in(acc_carry_in), .acc_value(acc_value),
    .acc_updated(acc_updated), .acc_overflow(acc_overflow), .acc_carry_out(acc_carry_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_value(result_value), .result_overflow(result_overflow), .result_carry(result_carry),
    .error_spurious_update(error_spurious_update), .error_timeout(error_timeout)
  );

  // Accumulator model: {updated, overflow, carry, value} delayed by 1+extra_stages edges.
  logic [7:0]  m_acc;
  logic [10:0] m_pipe [0:3];
  logic [10:0] m_stage;
  logic [8:0]  m_sum;
  int extra_stages  = 0;
  bit drop_updates  = 1'b0;
  bit inject_update = 1'b0;
  bit model_reset   = 1'b0;

  always @(posedge clock) begin
    m_stage = '0;
    if (acc_load_valid) m_stage = {3'b100, acc_load_value};
    else if (acc_increment_valid) begin
      m_sum   = {1'b0, m_acc} + {1'b0, acc_increment};
      m_stage = {1'b1, (m_acc[7] == acc_increment[7]) && (m_sum[7] != m_acc[7]), m_sum[8], m_sum[7:0]};
    end
    if (drop_updates) m_stage[10] = 1'b0;
    if (model_reset) begin
      m_acc <= '0;
      for (int i = 0; i < 4; i++) m_pipe[i] <= '0;
    end else begin
      if (acc_load_valid || acc_increment_valid) m_acc <= m_stage[7:0];
      m_pipe[0] <= m_stage;
      for (int i = 1; i < 4; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  assign acc_updated   = m_pipe[extra_stages][10] | inject_update;
  assign acc_overflow  = m_pipe[extra_stages][9];
  assign acc_carry_out = m_pipe[extra_stages][8];
  assign acc_value     = m_pipe[extra_stages][7:0];

  // Edge-numbered event monitor and result collector.
  int cyc = 0, hs_count = 0, last_hs = 0, prev_hs = 0;
  int inc_pulses = 0, load_pulses = 0, last_pulse = 0, last_upd = 0;
  logic [9:0] res_q [$];
  logic [9:0] exp_q [$];

  always @(posedge clock) begin
    cyc++;
    if (!clear) begin
      if (cmd_valid && cmd_ready) begin hs_count++; prev_hs = last_hs; last_hs = cyc; end
      if (acc_increment_valid) begin inc_pulses++; last_pulse = cyc; end
      if (acc_load_valid) begin load_pulses++; last_pulse = cyc; end
      if (acc_updated) last_upd = cyc;
      if (result_valid && result_ready) res_q.push_back({result_value, result_overflow, result_carry});
    end
  end

  task automatic send_cmd(input bit is_load, input logic [7:0] val, output int hs_edge, output bit ok);
    int start = hs_count;
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_is_load = is_load; cmd_value = val;
    while (hs_count == start && n < 200) begin @(negedge clock); n++; end
    cmd_valid = 1'b0;
    ok = (hs_count != start);
    hs_edge = last_hs;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int k = 0;
    while (res_q.size() < n && k < 200) begin @(negedge clock); k++; end
    ok = (res_q.size() >= n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    clear = 1'b1; model_reset = 1'b1;
    cmd_valid = 1'b0; cmd_is_load = 1'b0; cmd_value = '0; result_ready = 1'b1;
    idle(3);
    clear = 1'b0; model_reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmd_ready, acc_increment_valid, acc_load_valid, result_valid, error_spurious_update, error_timeout, acc_carry_in} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, expected 1000000", {cmd_ready, acc_increment_valid, acc_load_valid, result_valid, error_spurious_update, error_timeout, acc_carry_in});
    end
    checks++;
    if ({result_value, result_overflow, result_carry} !== 10'h000) begin
      fails++; $display("FAIL reset_result: got %h, expected 000", {result_value, result_overflow, result_carry});
    end
  endtask

  task automatic test_increments;
    int hs, p0;
    bit ok;
    logic [9:0] got, want;
    extra_stages = 0;
    p0 = inc_pulses;
    exp_q.push_back({8'd5, 1'b0, 1'b0});
    send_cmd(1'b0, 8'd5, hs, ok);
    checks++;
    if ({ok, cmd_ready, acc_increment_valid, acc_load_valid, acc_increment} !== {4'b1010, 8'd5}) begin
      fails++; $display("FAIL inc_issue: got %b_%h, expected 1010_05", {ok, cmd_ready, acc_increment_valid, acc_load_valid}, acc_increment);
    end
    @(negedge clock);
    checks++;
    if ({cmd_ready, acc_increment_valid} !== 2'b00) begin
      fails++; $display("FAIL inc_wait_ctrl: got %b, expected 00", {cmd_ready, acc_increment_valid});
    end
    wait_results(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL inc_result0: got none, expected %h", exp_q[0]); end
    else begin
      got = res_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin fails++; $display("FAIL inc_result0: got %h, expected %h", got, want); end
    end
    checks++;
    if (last_pulse !== hs + 1) begin fails++; $display("FAIL inc_pulse_edge: got %0d, expected %0d", last_pulse, hs + 1); end
    exp_q.push_back({8'd2, 1'b0, 1'b1});
    send_cmd(1'b0, 8'hFD, hs, ok);
    wait_results(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL inc_result1: got none, expected %h", exp_q[0]); end
    else begin
      got = res_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin fails++; $display("FAIL inc_result1: got %h, expected %h", got, want); end
    end
    checks++;
    if (inc_pulses - p0 !== 2) begin fails++; $display("FAIL inc_pulse_count: got %0d, expected 2", inc_pulses - p0); end
  endtask

  task automatic test_load_overflow;
    int hs, l0, i0;
    bit ok;
    logic [9:0] got, want;
    idle(6);
    extra_stages = 2;
    l0 = load_pulses; i0 = inc_pulses;
    exp_q.push_back({8'd127, 1'b0, 1'b0});
    send_cmd(1'b1, 8'd127, hs, ok);
    checks++;
    if ({ok, acc_load_valid, acc_increment_valid, acc_load_value} !== {3'b110, 8'd127}) begin
      fails++; $display("FAIL load_issue: got %b_%h, expected 110_7f", {ok, acc_load_valid, acc_increment_valid}, acc_load_value);
    end
    wait_results(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL load_result: got none, expected %h", exp_q[0]); end
    else begin
      got = res_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin fails++; $display("FAIL load_result: got %h, expected %h", got, want); end
    end
    checks++;
    if (last_upd !== hs + 4) begin fails++; $display("FAIL load_update_edge: got %0d, expected %0d", last_upd, hs + 4); end
    checks++;
    if ({load_pulses - l0, inc_pulses - i0} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL load_pulse_count: got %0d/%0d, expected 1/0", load_pulses - l0, inc_pulses - i0);
    end
    exp_q.push_back({8'h80, 1'b1, 1'b0});
    send_cmd(1'b0, 8'd1, hs, ok);
    wait_results(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL overflow_result: got none, expected %h", exp_q[0]); end
    else begin
      got = res_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin fails++; $display("FAIL overflow_result: got %h, expected %h", got, want); end
    end
  endtask

  task automatic test_back_to_back;
    int h0, n;
    bit ok;
    logic [9:0] got, want;
    idle(6);
    extra_stages = 0;
    h0 = hs_count; n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_is_load = 1'b0; cmd_value = 8'd1;
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    while (hs_count == h0 && n < 100) begin @(negedge clock); n++; end
    cmd_value = 8'd2;
    exp_q.push_back({8'h83, 1'b0, 1'b0});
    while (hs_count == h0 + 1 && n < 100) begin @(negedge clock); n++; end
    cmd_valid = 1'b0;
    checks++;
    if (hs_count - h0 !== 2 || last_hs - prev_hs !== 4) begin
      fails++; $display("FAIL b2b_spacing: got %0d cmds %0d apart, expected 2 cmds 4 apart", hs_count - h0, last_hs - prev_hs);
    end
    wait_results(2, ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!ok) begin fails++; $display("FAIL b2b_result%0d: got none, expected result", i); end
      else begin
        got = res_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL b2b_result%0d: got %h, expected %h", i, got, want); end
      end
    end
  endtask

  task automatic test_backpressure;
    int hs, p0, n, h0;
    bit ok, bad;
    logic [7:0] held;
    logic [9:0] got, want;
    idle(4);
    result_ready = 1'b0;
    exp_q.push_back({8'h85, 1'b0, 1'b0});
    send_cmd(1'b0, 8'd2, hs, ok);
    n = 0;
    while (!result_valid && n < 50) begin @(negedge clock); n++; end
    held = result_value;
    checks++;
    if ({result_valid, held} !== {1'b1, 8'h85}) begin
      fails++; $display("FAIL bp_result_held: got %b_%h, expected 1_85", result_valid, held);
    end
    cmd_valid = 1'b1; cmd_is_load = 1'b0; cmd_value = 8'd3;
    exp_q.push_back({8'h88, 1'b0, 1'b0});
    p0 = inc_pulses + load_pulses; h0 = hs_count;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (result_valid !== 1'b1 || result_value !== held || cmd_ready !== 1'b0 || inc_pulses + load_pulses != p0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++; $display("FAIL bp_stall: got valid=%b value=%h ready=%b pulses=%0d, expected 1/%h/0/%0d", result_valid, result_value, cmd_ready, inc_pulses + load_pulses, held, p0);
    end
    result_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({res_q.size() == 1, cmd_ready, result_valid, hs_count == h0} !== 4'b1101) begin
      fails++; $display("FAIL bp_release: got results=%0d ready=%b valid=%b, expected 1/1/0", res_q.size(), cmd_ready, result_valid);
    end
    n = 0;
    while (hs_count == h0 && n < 20) begin @(negedge clock); n++; end
    cmd_valid = 1'b0;
    wait_results(2, ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!ok) begin fails++; $display("FAIL bp_result%0d: got none, expected result", i); end
      else begin
        got = res_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL bp_result%0d: got %h, expected %h", i, got, want); end
      end
    end
  endtask

  task automatic test_timeout;
    int hs, n;
    bit ok;
    logic [9:0] got, want;
    idle(4);
    drop_updates = 1'b1;
    send_cmd(1'b0, 8'd1, hs, ok);
    n = 0;
    while (!error_timeout && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (!error_timeout || cyc - hs !== 17) begin
      fails++; $display("FAIL timeout_edge: got flag=%b after %0d edges, expected 1 after 17", error_timeout, cyc - hs);
    end
    checks++;
    if ({cmd_ready, result_valid, error_spurious_update, res_q.size() == 0} !== 4'b1001) begin
      fails++; $display("FAIL timeout_state: got ready=%b valid=%b spurious=%b results=%0d, expected 1/0/0/0", cmd_ready, result_valid, error_spurious_update, res_q.size());
    end
    drop_updates = 1'b0;
    exp_q.push_back({8'd10, 1'b0, 1'b0});
    send_cmd(1'b1, 8'd10, hs, ok);
    wait_results(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL timeout_next: got none, expected %h", exp_q[0]); end
    else begin
      got = res_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin fails++; $display("FAIL timeout_next: got %h, expected %h", got, want); end
    end
  endtask

  task automatic test_spurious;
    idle(4);
    inject_update = 1'b1;
    @(negedge clock);
    inject_update = 1'b0;
    checks++;
    if ({error_spurious_update, result_valid, cmd_ready} !== 3'b101) begin
      fails++; $display("FAIL spurious_flag: got %b, expected 101", {error_spurious_update, result_valid, cmd_ready});
    end
    idle(5);
    checks++;
    if ({error_spurious_update, error_timeout, res_q.size() == 0} !== 3'b111) begin
      fails++; $display("FAIL spurious_sticky: got spurious=%b timeout=%b results=%0d, expected 1/1/0", error_spurious_update, error_timeout, res_q.size());
    end
  endtask

  task automatic test_clear_mid_wait;
    int hs;
    bit ok;
    drop_updates = 1'b1;
    send_cmd(1'b0, 8'd1, hs, ok);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    inject_update = 1'b1;
    @(negedge clock);
    inject_update = 1'b0;
    checks++;
    if ({error_spurious_update, error_timeout, cmd_ready, result_valid} !== 4'b0010) begin
      fails++; $display("FAIL clear_mid_wait: got %b, expected 0010", {error_spurious_update, error_timeout, cmd_ready, result_valid});
    end
    idle(3);
    checks++;
    if ({error_spurious_update, res_q.size() == 0} !== 2'b01) begin
      fails++; $display("FAIL clear_no_result: got spurious=%b results=%0d, expected 0/0", error_spurious_update, res_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_increments;
    test_load_overflow;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_spurious;
    test_clear_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
